// File: rtl/bit_stream_monitor.sv
// ============================================================================
// Module   : bit_stream_monitor
// Purpose  : Serial pattern detector with match, ones, bit and run counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_stream_monitor #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic [CNT_W-1:0] ones_count,
   output logic [CNT_W-1:0] total_count,
   output logic [CNT_W-1:0] run_len,
   output logic [CNT_W-1:0] max_run
);

   localparam int               FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [PAT_W-1:0]  hist_q,        hist_d;
   logic [FILL_W-1:0] fill_q,        fill_d;
   logic              match_q,       match_d;
   logic [CNT_W-1:0]  match_count_q, match_count_d;
   logic [CNT_W-1:0]  ones_count_q,  ones_count_d;
   logic [CNT_W-1:0]  total_count_q, total_count_d;
   logic [CNT_W-1:0]  run_len_q,     run_len_d;
   logic [CNT_W-1:0]  max_run_q,     max_run_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   always_comb begin
      hist_d        = hist_q;
      fill_d        = fill_q;
      match_d       = 1'b0;
      match_count_d = match_count_q;
      ones_count_d  = ones_count_q;
      total_count_d = total_count_q;
      run_len_d     = run_len_q;
      max_run_d     = max_run_q;

      if (clear) begin
         hist_d        = '0;
         fill_d        = '0;
         match_count_d = '0;
         ones_count_d  = '0;
         total_count_d = '0;
         run_len_d     = '0;
         max_run_d     = '0;
      end else if (in_valid) begin
         hist_d        = {hist_q[PAT_W-2:0], in_bit};
         fill_d        = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
         total_count_d = sat_inc(total_count_q);
         if (in_bit) begin
            ones_count_d = sat_inc(ones_count_q);
            run_len_d    = sat_inc(run_len_q);
         end else begin
            run_len_d    = '0;
         end
         if (run_len_d > max_run_q)
            max_run_d = run_len_d;
         // Detection looks at the freshly shifted history, so overlaps count.
         if ((fill_d == FILL_FULL) && (hist_d == PATTERN)) begin
            match_d       = 1'b1;
            match_count_d = sat_inc(match_count_q);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q        <= '0;
         fill_q        <= '0;
         match_q       <= 1'b0;
         match_count_q <= '0;
         ones_count_q  <= '0;
         total_count_q <= '0;
         run_len_q     <= '0;
         max_run_q     <= '0;
      end else begin
         hist_q        <= hist_d;
         fill_q        <= fill_d;
         match_q       <= match_d;
         match_count_q <= match_count_d;
         ones_count_q  <= ones_count_d;
         total_count_q <= total_count_d;
         run_len_q     <= run_len_d;
         max_run_q     <= max_run_d;
      end
   end

   assign match       = match_q;
   assign match_count = match_count_q;
   assign ones_count  = ones_count_q;
   assign total_count = total_count_q;
   assign run_len     = run_len_q;
   assign max_run     = max_run_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_stream_monitor.sv
// ============================================================================
// Module   : tb_bit_stream_monitor
// Purpose  : Scoreboard bench for bit_stream_monitor (CNT_W 8 and 4 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_stream_monitor;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_bit = 1'b0;
   logic clear = 1'b0;

   logic       m8, m4;
   logic [7:0] mc8, oc8, tc8, rl8, mr8;
   logic [3:0] mc4, oc4, tc4, rl4, mr4;

   always #5 clk = ~clk;

   bit_stream_monitor dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
      .match(m8), .match_count(mc8), .ones_count(oc8), .total_count(tc8),
      .run_len(rl8), .max_run(mr8)
   );

   bit_stream_monitor #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
      .match(m4), .match_count(mc4), .ones_count(oc4), .total_count(tc4),
      .run_len(rl4), .max_run(mr4)
   );

   typedef struct {
      bit m;
      int tot, ones, run, mx, mc;
   } exp_t;

   exp_t       sb[$];
   bit         hist[$];   // every bit accepted since the last reset/clear
   bit         mflag;
   logic [3:0] pat = 4'b1011;
   int         n_cmp = 0;
   int         n_fail = 0;
   bit         done = 0;

   function automatic int sat(input int v, input int w);
      int lim;
      lim = (1 << w) - 1;
      return (v > lim) ? lim : v;
   endfunction

   function automatic bit window_hit(input int last);
      if (last < 3) return 0;
      for (int k = 0; k < 4; k++)
         if (hist[last-3+k] != pat[3-k]) return 0;
      return 1;
   endfunction

   function automatic exp_t model_state();
      exp_t e;
      int cur;
      e.m = mflag; e.tot = hist.size(); e.ones = 0; e.run = 0; e.mx = 0; e.mc = 0;
      cur = 0;
      for (int i = 0; i < hist.size(); i++) begin
         if (hist[i]) begin e.ones++; cur++; end else cur = 0;
         if (cur > e.mx) e.mx = cur;
         if (window_hit(i)) e.mc++;
      end
      e.run = cur;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic chk_all(input exp_t e);
      chk("match8", int'(m8), int'(e.m));
      chk("match4", int'(m4), int'(e.m));
      chk("match_count8", int'(mc8), sat(e.mc, 8));
      chk("ones_count8", int'(oc8), sat(e.ones, 8));
      chk("total_count8", int'(tc8), sat(e.tot, 8));
      chk("run_len8", int'(rl8), sat(e.run, 8));
      chk("max_run8", int'(mr8), sat(e.mx, 8));
      chk("match_count4", int'(mc4), sat(e.mc, 4));
      chk("ones_count4", int'(oc4), sat(e.ones, 4));
      chk("total_count4", int'(tc4), sat(e.tot, 4));
      chk("run_len4", int'(rl4), sat(e.run, 4));
      chk("max_run4", int'(mr4), sat(e.mx, 4));
   endtask

   // One clock of stimulus; the expected post-edge state goes to the scoreboard.
   task automatic step(input bit v, input bit b, input bit c);
      @(negedge clk);
      in_valid = v; in_bit = b; clear = c;
      if (c) begin
         hist.delete(); mflag = 0;
      end else if (v) begin
         hist.push_back(b);
         mflag = window_hit(hist.size() - 1);
      end else begin
         mflag = 0;
      end
      sb.push_back(model_state());
   endtask

   task automatic feed(input bit bits[$], input int gap);
      foreach (bits[i]) begin
         step(1, bits[i], 0);
         for (int g = 0; g < gap; g++) step(0, $urandom_range(0, 1), 0);
      end
      step(0, 0, 0);
   endtask

   task automatic async_reset(input string tag);
      exp_t z;
      @(negedge clk);
      in_valid = 0; clear = 0;
      chk({tag, "_pre_match"}, int'(m8), int'(mflag));
      #1 reset = 1;
      #1;
      hist.delete(); mflag = 0;
      z = model_state();
      chk_all(z);
      #1 reset = 0;
   endtask

   // Monitor: each edge produces one registered state; compare it just after.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) chk_all(sb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
      $fatal(1, "timeout");
   end

   initial begin
      bit seq1[$] = '{1, 0, 1, 1, 0, 1, 1};
      bit seq3[$] = '{1, 0, 1};
      bit seq5[$] = '{1, 1, 1, 0, 1, 1};
      bit seq6[$] = '{1, 0, 1, 1};
      bit ones20[$];
      exp_t z;

      mflag = 0;
      #3;
      z = model_state();
      chk_all(z);
      @(negedge clk);
      #2 reset = 0;

      feed(seq1, 0);
      step(0, 0, 1);
      feed(seq1, 3);

      step(0, 0, 1);
      feed(seq3, 0);
      step(1, 1, 1);
      step(1, 1, 0);
      step(0, 0, 0);

      step(0, 0, 1);
      for (int i = 0; i < 20; i++) ones20.push_back(1);
      feed(ones20, 0);

      step(0, 0, 1);
      feed(seq5, 0);

      step(0, 0, 1);
      step(1, 1, 0);
      step(1, 0, 0);
      async_reset("mid_pattern");
      step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
      async_reset("during_match");
      feed(seq6, 0);
      chk("fresh_seq_matches", int'(model_state().mc), 1);

      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
      step(0, 0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      done = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
